// File: rtl/gravity_tick_ctrl.sv
// ============================================================================
// gravity_tick_ctrl : counts delay-counter expiries into gravity drop requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module gravity_tick_ctrl #(
    parameter int CNT_W    = 5,
    parameter int BASE_DIV = 16,
    parameter int STEP     = 1,
    parameter int LEVEL_W  = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] level,
    input  logic               soft_drop,
    input  logic               hard_drop,
    input  logic               timer_out,
    input  logic               drop_ack,
    output logic               timer_start,
    output logic               timer_interrupt,
    output logic               drop_req,
    output logic               drop_src,
    output logic [CNT_W-1:0]   tick_cnt
);

    localparam int DW = CNT_W + LEVEL_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_REQ  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_timer_q;
    logic               r_timer_start;
    logic               r_timer_interrupt;
    logic               r_drop_req;
    logic               r_drop_src;
    logic [CNT_W-1:0]   r_tick_cnt;

    logic               w_expiry;
    logic [DW-1:0]      w_prod;
    logic [DW-1:0]      w_diff;
    logic [DW-1:0]      w_div;
    logic [DW-1:0]      w_tick_next;
    logic               w_final;

    assign w_expiry = timer_out & ~r_timer_q;

    // The difference is treated as signed: a set MSB or zero means the level
    // has pushed the divisor to (or past) zero, so it saturates to one.
    assign w_prod      = DW'(level) * DW'(STEP);
    assign w_diff      = DW'(BASE_DIV) - w_prod;
    assign w_div       = (soft_drop || w_diff[DW-1] || (w_diff == '0)) ? DW'(1) : w_diff;
    assign w_tick_next = DW'(r_tick_cnt) + DW'(1);
    assign w_final     = (w_tick_next >= w_div);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state           <= S_IDLE;
            r_timer_q         <= 1'b0;
            r_timer_start     <= 1'b0;
            r_timer_interrupt <= 1'b0;
            r_drop_req        <= 1'b0;
            r_drop_src        <= 1'b0;
            r_tick_cnt        <= '0;
        end else begin
            r_timer_q         <= timer_out;
            r_timer_start     <= 1'b0;
            r_timer_interrupt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state       <= S_ARM;
                        r_timer_start <= 1'b1;
                    end
                end
                S_ARM: begin
                    r_state <= enable ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (!enable) begin
                        r_state           <= S_IDLE;
                        r_timer_interrupt <= 1'b1;
                        r_tick_cnt        <= '0;
                    end else if (hard_drop) begin
                        r_state           <= S_REQ;
                        r_timer_interrupt <= 1'b1;
                        r_tick_cnt        <= '0;
                        r_drop_src        <= 1'b1;
                        r_drop_req        <= 1'b1;
                    end else if (w_expiry) begin
                        if (w_final) begin
                            r_state    <= S_REQ;
                            r_tick_cnt <= '0;
                            r_drop_src <= 1'b0;
                            r_drop_req <= 1'b1;
                        end else begin
                            r_state       <= S_ARM;
                            r_timer_start <= 1'b1;
                            r_tick_cnt    <= r_tick_cnt + CNT_W'(1);
                        end
                    end
                end
                S_REQ: begin
                    if (drop_ack) begin
                        r_drop_req <= 1'b0;
                        if (enable) begin
                            r_state       <= S_ARM;
                            r_timer_start <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign timer_start     = r_timer_start;
    assign timer_interrupt = r_timer_interrupt;
    assign drop_req        = r_drop_req;
    assign drop_src        = r_drop_src;
    assign tick_cnt        = r_tick_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gravity_tick_ctrl.sv
// ============================================================================
// tb_gravity_tick_ctrl : directed self-checking bench for gravity_tick_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gravity_tick_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [3:0] level;
    logic       soft_drop;
    logic       hard_drop;
    logic       timer_out;
    logic       drop_ack;
    logic       timer_start;
    logic       timer_interrupt;
    logic       drop_req;
    logic       drop_src;
    logic [4:0] tick_cnt;

    logic       use_model;
    logic       tb_out;
    logic       m_out;
    logic       m_run;
    int         m_cnt;

    int n_err    = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    gravity_tick_ctrl #(
        .CNT_W(5), .BASE_DIV(16), .STEP(1), .LEVEL_W(4)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .level(level),
        .soft_drop(soft_drop), .hard_drop(hard_drop), .timer_out(timer_out),
        .drop_ack(drop_ack), .timer_start(timer_start),
        .timer_interrupt(timer_interrupt), .drop_req(drop_req),
        .drop_src(drop_src), .tick_cnt(tick_cnt)
    );

    assign timer_out = use_model ? m_out : tb_out;

    // Delay-counter model: one-cycle expiry 33 cycles after a start.
    always @(posedge clk) begin
        if (!resetn || timer_interrupt) begin
            m_run <= 1'b0;
            m_cnt <= 0;
            m_out <= 1'b0;
        end else if (timer_start) begin
            m_run <= 1'b1;
            m_cnt <= 1;
            m_out <= 1'b0;
        end else if (m_run) begin
            if (m_cnt == 33) begin
                m_out <= 1'b1;
                m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
                m_out <= 1'b0;
            end
        end else begin
            m_out <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        tb_out = 1'b1;
        step();
        tb_out = 1'b0;
        step();
    endtask

    task automatic wait_req(input string tag, input int bound);
        int i;
        for (i = 0; i < bound && !drop_req; i++) step();
        chk(tag, 32'(drop_req), 32'd1);
    endtask

    initial begin
        int n_start, n_exp, max_tick, last_exp, rise;
        resetn = 1'b0; enable = 1'b0; level = 4'd0; soft_drop = 1'b0;
        hard_drop = 1'b0; drop_ack = 1'b0; use_model = 1'b1; tb_out = 1'b0;
        step(); step(); step();
        chk("rst_start", 32'(timer_start), 32'd0);
        chk("rst_intr", 32'(timer_interrupt), 32'd0);
        chk("rst_req", 32'(drop_req), 32'd0);
        chk("rst_src", 32'(drop_src), 32'd0);
        chk("rst_tick", 32'(tick_cnt), 32'd0);

        // Level 0: sixteen expiries per drop.
        resetn = 1'b1; enable = 1'b1;
        n_start = 0; n_exp = 0; max_tick = 0; last_exp = -100; rise = -1;
        for (int i = 0; i < 1200 && !drop_req; i++) begin
            step();
            if (timer_start) n_start++;
            if (timer_out) begin n_exp++; last_exp = i; end
            if (int'(tick_cnt) > max_tick) max_tick = int'(tick_cnt);
            if (drop_req) rise = i;
        end
        chk("l0_req", 32'(drop_req), 32'd1);
        chk("l0_starts", 32'(n_start), 32'd16);
        chk("l0_expiries", 32'(n_exp), 32'd16);
        chk("l0_max_tick", 32'(max_tick), 32'd15);
        chk("l0_latency", 32'(rise - last_exp), 32'd1);
        chk("l0_src", 32'(drop_src), 32'd0);
        chk("l0_tick", 32'(tick_cnt), 32'd0);
        drop_ack = 1'b1; level = 4'd15;
        step();
        drop_ack = 1'b0;
        chk("ack_req", 32'(drop_req), 32'd0);
        chk("ack_start", 32'(timer_start), 32'd1);
        chk("ack_tick", 32'(tick_cnt), 32'd0);

        // Level 15: divisor saturates at one.
        wait_req("l15_req", 100);
        chk("l15_tick", 32'(tick_cnt), 32'd0);
        chk("l15_src", 32'(drop_src), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_req", 32'(drop_req), 32'd1);
            chk("hold_start", 32'(timer_start), 32'd0);
        end
        drop_ack = 1'b1; level = 4'd12; soft_drop = 1'b1;
        step();
        drop_ack = 1'b0;
        chk("ack2_start", 32'(timer_start), 32'd1);
        wait_req("soft_req", 100);
        chk("soft_tick", 32'(tick_cnt), 32'd0);
        drop_ack = 1'b1;
        step();
        drop_ack = 1'b0; use_model = 1'b0; soft_drop = 1'b0; level = 4'd0;
        step();

        // Hard drop beats a simultaneous expiry at tick 7.
        for (int i = 0; i < 7; i++) pulse();
        chk("hd_pre_tick", 32'(tick_cnt), 32'd7);
        hard_drop = 1'b1; tb_out = 1'b1;
        step();
        hard_drop = 1'b0; tb_out = 1'b0;
        chk("hd_intr", 32'(timer_interrupt), 32'd1);
        chk("hd_req", 32'(drop_req), 32'd1);
        chk("hd_src", 32'(drop_src), 32'd1);
        chk("hd_tick", 32'(tick_cnt), 32'd0);
        step();
        chk("hd_intr_once", 32'(timer_interrupt), 32'd0);
        chk("hd_req_held", 32'(drop_req), 32'd1);
        drop_ack = 1'b1;
        step();
        drop_ack = 1'b0;
        step();

        // Disable at tick 5 aborts the timer.
        for (int i = 0; i < 5; i++) pulse();
        chk("dis_pre_tick", 32'(tick_cnt), 32'd5);
        enable = 1'b0;
        step();
        chk("dis_intr", 32'(timer_interrupt), 32'd1);
        chk("dis_tick", 32'(tick_cnt), 32'd0);
        chk("dis_req", 32'(drop_req), 32'd0);
        step();
        chk("dis_intr_once", 32'(timer_interrupt), 32'd0);
        enable = 1'b1;
        step();
        chk("reen_start", 32'(timer_start), 32'd1);
        step();

        // Held timer_out counts once; stray ack ignored.
        tb_out = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tb_out = 1'b0;
        step();
        chk("held_tick", 32'(tick_cnt), 32'd1);
        drop_ack = 1'b1;
        step();
        drop_ack = 1'b0;
        chk("stray_req", 32'(drop_req), 32'd0);
        chk("stray_tick", 32'(tick_cnt), 32'd1);

        // Level rise below the current count drops on the next expiry.
        for (int i = 0; i < 4; i++) pulse();
        chk("lvl_pre_tick", 32'(tick_cnt), 32'd5);
        level = 4'd13;
        tb_out = 1'b1;
        step();
        tb_out = 1'b0;
        chk("lvl_req", 32'(drop_req), 32'd1);
        chk("lvl_src", 32'(drop_src), 32'd0);
        chk("lvl_tick", 32'(tick_cnt), 32'd0);

        // Reset while a request is pending.
        resetn = 1'b0; enable = 1'b0;
        step();
        chk("mr_req", 32'(drop_req), 32'd0);
        chk("mr_tick", 32'(tick_cnt), 32'd0);
        chk("mr_intr", 32'(timer_interrupt), 32'd0);
        resetn = 1'b1;
        step();
        chk("mr_idle_start", 32'(timer_start), 32'd0);
        chk("mr_idle_intr", 32'(timer_interrupt), 32'd0);
        enable = 1'b1;
        step();
        chk("mr_en_start", 32'(timer_start), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
